// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: NUM_CH-channel hobby-servo PWM generator on a Wishbone slave.
// A 1 us tick from a prescaler drives a frame counter; each channel outputs a
// pulse of current[n] us per frame. current[n] slews toward a clamped target
// once per frame.
// Ports:
//   clk, rstn            core clock, asynchronous active-low reset
//   i_wb_adr/dat/we/cyc/stb, o_wb_ack/o_wb_rdt   Wishbone register port
//   o_pwm[NUM_CH-1:0]    registered servo pulses, bit n = channel n
//   o_frame              one-clock pulse at each frame boundary
module servo_pwm_multi #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned TICK_DIV  = 25,
  parameter int unsigned PERIOD_US = 20000,
  parameter int unsigned MIN_US    = 500,
  parameter int unsigned MAX_US    = 2500,
  parameter int unsigned CENTER_US = 1500
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [4:0]        i_wb_adr,
  input  logic [31:0]       i_wb_dat,
  input  logic              i_wb_we,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  output logic              o_wb_ack,
  output logic [31:0]       o_wb_rdt,
  output logic [NUM_CH-1:0] o_pwm,
  output logic              o_frame
);

  localparam int unsigned UW = 16;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [UW-1:0] MIN_W      = UW'(MIN_US);
  localparam logic [UW-1:0] MAX_W      = UW'(MAX_US);
  localparam logic [UW-1:0] CENTER_W   = UW'(CENTER_US);
  localparam logic [UW-1:0] LAST_US    = UW'(PERIOD_US - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  localparam logic [4:0] ADR_CTRL   = 5'd0;
  localparam logic [4:0] ADR_SLEW   = 5'd1;
  localparam logic [4:0] ADR_STATUS = 5'd2;

  // Register state
  logic              gen_en_q, gen_en_d;
  logic [NUM_CH-1:0] ch_en_q, ch_en_d;
  logic [UW-1:0]     slew_q, slew_d;
  logic [UW-1:0]     frame_cnt_q, frame_cnt_d;
  logic [UW-1:0]     target_q  [NUM_CH];
  logic [UW-1:0]     target_d  [NUM_CH];
  logic [UW-1:0]     current_q [NUM_CH];
  logic [UW-1:0]     current_d [NUM_CH];

  // Timebase state
  logic [PW-1:0]     presc_q, presc_d;
  logic [UW-1:0]     us_cnt_q, us_cnt_d;
  logic              started_q, started_d;

  // Output registers
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              frame_q, frame_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdt_q, rdt_d;

  logic              access_c;
  logic              wr_c;
  logic              tick_c;
  logic              boundary_c;
  logic [31:0]       rd_c;
  logic              unused_dat_c;

  // Data bits that no register stores.
  assign unused_dat_c = ^i_wb_dat[30:16];

  function automatic logic [UW-1:0] clamp_us(input logic [UW-1:0] v);
    logic [UW-1:0] r;
    r = v;
    if (v < MIN_W) r = MIN_W;
    if (v > MAX_W) r = MAX_W;
    return r;
  endfunction

  // One frame's move of cur toward tgt, limited to slew (0 = jump); 17-bit difference.
  function automatic logic [UW-1:0] slew_step(input logic [UW-1:0] cur,
                                              input logic [UW-1:0] tgt,
                                              input logic [UW-1:0] slew);
    logic [UW:0]   mag;
    logic [UW-1:0] step;
    logic [UW-1:0] r;
    mag  = (tgt >= cur) ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt});
    step = (mag < {1'b0, slew}) ? mag[UW-1:0] : slew;
    if (slew == '0)      r = tgt;
    else if (tgt >= cur) r = cur + step;
    else                 r = cur - step;
    return r;
  endfunction

  assign access_c = i_wb_cyc & i_wb_stb & ~ack_q;
  assign wr_c     = access_c & i_wb_we;
  assign tick_c   = gen_en_q & (presc_q == PRESC_LAST);
  // First tick after enable starts a frame without advancing us_cnt.
  assign boundary_c = tick_c & (~started_q | (us_cnt_q == LAST_US));

  // Prescaler and frame counter
  always_comb begin
    presc_d   = presc_q;
    us_cnt_d  = us_cnt_q;
    started_d = started_q;
    if (!gen_en_q) begin
      presc_d   = '0;
      us_cnt_d  = '0;
      started_d = 1'b0;
    end else begin
      presc_d = tick_c ? '0 : presc_q + PW'(1);
      if (tick_c) begin
        if (!started_q)               started_d = 1'b1;
        else if (us_cnt_q == LAST_US) us_cnt_d  = '0;
        else                          us_cnt_d  = us_cnt_q + UW'(1);
      end
    end
  end

  // Register reads sample pre-edge state
  always_comb begin
    rd_c = '0;
    case (i_wb_adr)
      ADR_CTRL: begin
        rd_c[31]         = gen_en_q;
        rd_c[NUM_CH-1:0] = ch_en_q;
      end
      ADR_SLEW:   rd_c = {16'h0, slew_q};
      ADR_STATUS: rd_c = {15'h0, gen_en_q, frame_cnt_q};
      default:    ;
    endcase
    for (int n = 0; n < NUM_CH; n++) begin
      if (i_wb_adr == 5'(8 + n))  rd_c = {16'h0, target_q[n]};
      if (i_wb_adr == 5'(16 + n)) rd_c = {16'h0, current_q[n]};
    end
  end

  // Register writes, slew update and output next-state
  always_comb begin
    gen_en_d    = gen_en_q;
    ch_en_d     = ch_en_q;
    slew_d      = slew_q;
    frame_cnt_d = frame_cnt_q;
    pwm_d       = '0;
    frame_d     = boundary_c;
    ack_d       = access_c;
    rdt_d       = (access_c && !i_wb_we) ? rd_c : '0;

    if (boundary_c) frame_cnt_d = frame_cnt_q + UW'(1);

    if (wr_c && i_wb_adr == ADR_CTRL) begin
      gen_en_d = i_wb_dat[31];
      ch_en_d  = i_wb_dat[NUM_CH-1:0];
    end
    if (wr_c && i_wb_adr == ADR_SLEW) slew_d = i_wb_dat[UW-1:0];

    for (int n = 0; n < NUM_CH; n++) begin
      // Slew uses the pre-write target, so a coincident write lands next frame.
      current_d[n] = boundary_c ? slew_step(current_q[n], target_q[n], slew_q) : current_q[n];
      target_d[n]  = (wr_c && i_wb_adr == 5'(8 + n)) ? clamp_us(i_wb_dat[UW-1:0]) : target_q[n];
      pwm_d[n]     = gen_en_q & ch_en_q[n] & started_q & (us_cnt_q < current_q[n]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gen_en_q    <= 1'b0;
      ch_en_q     <= '0;
      slew_q      <= '0;
      frame_cnt_q <= '0;
      presc_q     <= '0;
      us_cnt_q    <= '0;
      started_q   <= 1'b0;
      pwm_q       <= '0;
      frame_q     <= 1'b0;
      ack_q       <= 1'b0;
      rdt_q       <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        target_q[n]  <= CENTER_W;
        current_q[n] <= CENTER_W;
      end
    end else begin
      gen_en_q    <= gen_en_d;
      ch_en_q     <= ch_en_d;
      slew_q      <= slew_d;
      frame_cnt_q <= frame_cnt_d;
      presc_q     <= presc_d;
      us_cnt_q    <= us_cnt_d;
      started_q   <= started_d;
      pwm_q       <= pwm_d;
      frame_q     <= frame_d;
      ack_q       <= ack_d;
      rdt_q       <= rdt_d;
      for (int n = 0; n < NUM_CH; n++) begin
        target_q[n]  <= target_d[n];
        current_q[n] <= current_d[n];
      end
    end
  end

  assign o_pwm    = pwm_q;
  assign o_frame  = frame_q;
  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: a frame-time model predicts every output each
// clock; directed sequences pin pulse widths, clamping, slew and reset.
module tb_servo_pwm_multi;

  localparam int NCH = 4;
  localparam int PER = 100;
  localparam int MINV = 10;
  localparam int MAXV = 50;
  localparam int CEN = 30;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [4:0]      adr = '0;
  logic [31:0]     dat = '0;
  logic            we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic            ack;
  logic [31:0]     rdt;
  logic [NCH-1:0]  pwm;
  logic            frame;

  logic [4:0]      b1_adr = '0;
  logic [31:0]     b1_dat = '0;
  logic            b1_we = 1'b0, b1_cyc = 1'b0, b1_stb = 1'b0;
  logic            b1_ack;
  logic [31:0]     b1_rdt;
  logic [0:0]      b1_pwm;
  logic            b1_frame;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  servo_pwm_multi #(.NUM_CH(NCH), .TICK_DIV(1), .PERIOD_US(PER), .MIN_US(MINV),
                    .MAX_US(MAXV), .CENTER_US(CEN)) dut (
    .clk(clk), .rstn(rstn), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_we(we),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .o_wb_ack(ack), .o_wb_rdt(rdt),
    .o_pwm(pwm), .o_frame(frame));

  servo_pwm_multi #(.NUM_CH(1), .TICK_DIV(1), .PERIOD_US(PER), .MIN_US(MINV),
                    .MAX_US(MAXV), .CENTER_US(CEN)) dut1 (
    .clk(clk), .rstn(rstn), .i_wb_adr(b1_adr), .i_wb_dat(b1_dat), .i_wb_we(b1_we),
    .i_wb_cyc(b1_cyc), .i_wb_stb(b1_stb), .o_wb_ack(b1_ack), .o_wb_rdt(b1_rdt),
    .o_pwm(b1_pwm), .o_frame(b1_frame));

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // ---------------- model ----------------
  bit           m_en = 0;
  bit [NCH-1:0] m_ch = '0;
  int           m_slew = 0;
  int           m_fcnt = 0;
  int           m_k = 0;          // clocks since global enable took effect
  int           m_tgt [NCH] = '{CEN, CEN, CEN, CEN};
  int           m_cur [NCH] = '{CEN, CEN, CEN, CEN};
  bit [NCH-1:0] e_pwm = '0;
  bit           e_frame = 0;
  bit           e_ack = 0;
  logic [31:0]  e_rdt = '0;
  bit           m_bnd, m_acc;

  function automatic int clampv(input int v);
    if (v < MINV) return MINV;
    if (v > MAXV) return MAXV;
    return v;
  endfunction

  function automatic int slew_to(input int cur, input int tgt, input int s);
    int d;
    d = tgt - cur;
    if (s == 0) return tgt;
    if (d > 0) return cur + ((d < s) ? d : s);
    return cur - ((-d < s) ? -d : s);
  endfunction

  function automatic logic [31:0] m_read(input int a);
    logic [31:0] r;
    r = '0;
    if (a == 0) begin r[31] = m_en; r[NCH-1:0] = m_ch; end
    else if (a == 1) r = 32'(m_slew);
    else if (a == 2) r = 32'(m_fcnt) | (m_en ? 32'h1_0000 : 32'h0);
    else if (a >= 8 && a < 8 + NCH) r = 32'(m_tgt[a-8]);
    else if (a >= 16 && a < 16 + NCH) r = 32'(m_cur[a-16]);
    return r;
  endfunction

  // Frames begin on the first clock after enable and every PER clocks after;
  // pulses follow the frame start by one clock.
  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      m_en = 0; m_ch = '0; m_slew = 0; m_fcnt = 0; m_k = 0;
      for (int n = 0; n < NCH; n++) begin m_tgt[n] = CEN; m_cur[n] = CEN; end
      e_pwm = '0; e_frame = 0; e_ack = 0; e_rdt = '0;
    end else begin
      m_bnd = m_en && (m_k % PER == 0);
      for (int n = 0; n < NCH; n++)
        e_pwm[n] = m_en && m_ch[n] && (m_k >= 1) && (((m_k - 1) % PER) < m_cur[n]);
      e_frame = m_bnd;
      m_acc = cyc && stb && !e_ack;
      e_rdt = (m_acc && !we) ? m_read(int'(adr)) : 32'h0;
      if (m_bnd) begin
        m_fcnt = (m_fcnt + 1) % 65536;
        for (int n = 0; n < NCH; n++) m_cur[n] = slew_to(m_cur[n], m_tgt[n], m_slew);
      end
      m_k = m_en ? m_k + 1 : 0;
      e_ack = m_acc;
      if (m_acc && we) begin
        if (adr == 5'd0) begin m_en = dat[31]; m_ch = dat[NCH-1:0]; end
        else if (adr == 5'd1) m_slew = int'(dat[15:0]);
        else if (int'(adr) >= 8 && int'(adr) < 8 + NCH) m_tgt[int'(adr) - 8] = clampv(int'(dat[15:0]));
      end
    end
  end

  // Compare every clock
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("pwm", longint'(pwm), longint'(e_pwm));
      chk("frame", longint'(frame), longint'(e_frame));
      chk("ack", longint'(ack), longint'(e_ack));
      chk("rdt", longint'(rdt), longint'(e_rdt));
    end
  end

  // ---------------- bus / measurement tasks ----------------
  task automatic wb_write(input int a, input logic [31:0] d);
    @(negedge clk);
    adr = 5'(a); dat = d; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input int a, output logic [31:0] d);
    @(negedge clk);
    adr = 5'(a); we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d = rdt;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic wb1_read(input int a, output logic [31:0] d);
    @(negedge clk);
    b1_adr = 5'(a); b1_we = 1'b0; b1_cyc = 1'b1; b1_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d = b1_rdt;
    b1_cyc = 1'b0; b1_stb = 1'b0;
  endtask

  task automatic wait_frame();
    bit got;
    got = 0;
    for (int i = 0; i < 3 * PER && !got; i++) begin
      @(negedge clk);
      if (frame) got = 1;
    end
    if (!got) chk("frame_timeout", 0, 1);
  endtask

  int cnt [NCH];

  task automatic count_pulses();
    for (int n = 0; n < NCH; n++) cnt[n] = 0;
    repeat (PER) begin
      @(negedge clk);
      for (int n = 0; n < NCH; n++) if (pwm[n]) cnt[n]++;
    end
  endtask

  logic [31:0] rd;
  int          gap;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset
    #3;
    chk("rst_pwm", longint'(pwm), 0);
    chk("rst_ack", longint'(ack), 0);
    chk("rst_frame", longint'(frame), 0);
    chk("rst_rdt", longint'(rdt), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    cmp_en = 1;
    wb_read(16, rd); chk("cur0_reset", rd, 30);
    wb_read(2, rd);  chk("status_reset", rd, 0);

    // Basic 30/70 pulse and 100-clock frame
    wb_write(0, 32'h8000_0001);
    wait_frame();
    count_pulses();
    chk("pulse30", cnt[0], 30);
    chk("pulse30_ch1_off", cnt[1], 0);
    wait_frame();
    gap = 0;
    do begin @(negedge clk); gap++; end while (!frame && gap < 3 * PER);
    chk("frame_period", gap, 100);

    // Clamp
    wb_write(8, 32'd5);      wb_read(8, rd); chk("clamp_low", rd, 10);
    wb_write(8, 32'hFFFF);   wb_read(8, rd); chk("clamp_high", rd, 50);
    wait_frame();
    wb_read(16, rd); chk("cur_after_clamp", rd, 50);
    wait_frame();
    count_pulses();
    chk("pulse50", cnt[0], 50);

    // Slew
    wb_write(1, 32'd0); wb_write(8, 32'd30);
    wait_frame();
    wb_read(16, rd); chk("cur_back30", rd, 30);
    wb_write(1, 32'd7); wb_write(8, 32'd50);
    wait_frame(); wb_read(16, rd); chk("slew37", rd, 37);
    wait_frame(); wb_read(16, rd); chk("slew44", rd, 44);
    wait_frame(); wb_read(16, rd); chk("slew50", rd, 50);
    wait_frame(); wb_read(16, rd); chk("slew_hold50", rd, 50);
    wb_write(8, 32'd10);
    wait_frame(); wb_read(16, rd); chk("slew43", rd, 43);
    wait_frame(); wb_read(16, rd); chk("slew36", rd, 36);

    // Mid-frame target write does not alter the pulse in progress
    wb_write(1, 32'd0); wb_write(8, 32'd30);
    wait_frame();
    wait_frame();
    fork
      count_pulses();
      begin repeat (13) @(negedge clk); wb_write(8, 32'd10); end
    join
    chk("midframe_keep30", cnt[0], 30);
    wait_frame();
    count_pulses();
    chk("midframe_next10", cnt[0], 10);

    // Multi-channel
    wb_write(8, 32'd20); wb_write(10, 32'd40); wb_write(0, 32'h8000_0005);
    wait_frame();
    count_pulses();
    chk("multi_ch0", cnt[0], 20);
    chk("multi_ch1", cnt[1], 0);
    chk("multi_ch2", cnt[2], 40);
    chk("multi_ch3", cnt[3], 0);
    wb_read(11, rd);  chk("target3", rd, 30);
    wb_read(0, rd);   chk("ctrl_read", rd, 32'h8000_0005);
    wb_read(5, rd);   chk("unmapped", rd, 0);
    wb1_read(9, rd);  chk("dut1_idx9", rd, 0);
    wb1_read(8, rd);  chk("dut1_target0", rd, 30);

    // Held strobe is acked every other clock
    @(negedge clk);
    adr = 5'd1; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    gap = 0;
    repeat (4) begin @(negedge clk); if (ack) gap++; end
    cyc = 1'b0; stb = 1'b0;
    chk("ack_every_other", gap, 2);

    // Clearing global enable mid-frame
    wait_frame();
    repeat (5) @(negedge clk);
    chk("pwm_before_disable", longint'(pwm[0]), 1);
    wb_write(0, 32'h0000_0001);
    @(negedge clk);
    chk("pwm_after_disable", longint'(pwm), 0);
    wb_read(2, rd);
    chk("status_run_off", longint'(rd[16]), 0);
    chk("fcnt_retained", longint'(rd[15:0]), longint'(m_fcnt));
    chk("fcnt_nonzero", longint'(m_fcnt != 0), 1);
    wb_read(16, rd); chk("cur_retained", rd, 20);

    // Async reset mid-pulse
    wb_write(0, 32'h8000_0001);
    wait_frame();
    repeat (12) @(negedge clk);
    chk("pwm_before_reset", longint'(pwm[0]), 1);
    #2 rstn = 1'b0;
    #1;
    chk("pwm_async_reset", longint'(pwm), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    wb_read(2, rd);  chk("status_after_reset", rd, 0);
    wb_read(16, rd); chk("cur0_after_reset", rd, 30);
    wb_read(8, rd);  chk("tgt0_after_reset", rd, 30);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
